// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: turns received UART bytes into character-RAM writes for the
// VGA text screen, tracking the cursor, clearing the screen and echoing bytes.
module text_buffer_ctrl #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int ECHO_EN    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [6:0]        cur_col,
    output logic [4:0]        cur_row,
    output logic              busy,
    output logic              overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {CLEAR, IDLE, PROC, ECHO} state_t;

    state_t            state, stateNext;
    logic [ADDR_W-1:0] clearAddr, clearAddrNext;
    logic              echoPending, echoPendingNext;
    logic [7:0]        fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rdPtr, wrPtr;
    logic [PTR_W:0]    count;
    logic [7:0]        curByte;
    logic              pop, push;
    logic [ADDR_W-1:0] cellAddr;
    logic [6:0]        colNext;
    logic [4:0]        rowNext;
    logic              wrEnNext, txStartNext;
    logic [ADDR_W-1:0] wrAddrNext;
    logic [7:0]        wrDataNext, txDataNext;

    function automatic logic [4:0] nextRow(input logic [4:0] row);
        return (row == LAST_ROW) ? 5'd0 : row + 5'd1;
    endfunction

    // A full queue still accepts a byte when the same cycle pops one.
    assign pop      = (state == IDLE) && (count != '0);
    assign push     = rx_valid && ((count < DEPTH_C) || pop);
    assign cellAddr = ADDR_W'(cur_row) * COLS_A + ADDR_W'(cur_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (rx_valid && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= rx_data;
        if (pop)  curByte <= fifoMem[rdPtr];
    end

    always_comb begin
        stateNext       = state;
        clearAddrNext   = clearAddr;
        echoPendingNext = echoPending;
        colNext         = cur_col;
        rowNext         = cur_row;
        wrEnNext        = 1'b0;
        wrAddrNext      = wr_addr;
        wrDataNext      = wr_data;
        txStartNext     = 1'b0;
        txDataNext      = tx_data;
        case (state)
            CLEAR: begin
                wrEnNext   = 1'b1;
                wrAddrNext = clearAddr;
                wrDataNext = 8'h20;
                if (clearAddr == LAST_CELL) begin
                    clearAddrNext   = '0;
                    stateNext       = echoPending ? ECHO : IDLE;
                    echoPendingNext = 1'b0;
                end else begin
                    clearAddrNext = clearAddr + 1'b1;
                end
            end
            IDLE: if (pop) stateNext = PROC;
            PROC: begin
                stateNext = (ECHO_EN != 0) ? ECHO : IDLE;
                if ((curByte >= 8'h20) && (curByte <= 8'h7E)) begin
                    wrEnNext   = 1'b1;
                    wrAddrNext = cellAddr;
                    wrDataNext = curByte;
                    if (cur_col == LAST_COL) begin
                        colNext = 7'd0;
                        rowNext = nextRow(cur_row);
                    end else begin
                        colNext = cur_col + 7'd1;
                    end
                end else begin
                    case (curByte)
                        8'h0D: colNext = 7'd0;
                        8'h0A: rowNext = nextRow(cur_row);
                        8'h08: if (cur_col != 7'd0) begin
                            colNext    = cur_col - 7'd1;
                            wrEnNext   = 1'b1;
                            wrAddrNext = cellAddr - 1'b1;
                            wrDataNext = 8'h20;
                        end
                        // Form feed defers its echo until the sweep has finished.
                        8'h0C: begin
                            colNext         = 7'd0;
                            rowNext         = 5'd0;
                            stateNext       = CLEAR;
                            echoPendingNext = (ECHO_EN != 0);
                        end
                        default: stateNext = IDLE;
                    endcase
                end
            end
            ECHO: if (!tx_busy) begin
                txStartNext = 1'b1;
                txDataNext  = curByte;
                stateNext   = IDLE;
            end
            default: stateNext = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CLEAR;
            clearAddr   <= '0;
            echoPending <= 1'b0;
            cur_col     <= 7'd0;
            cur_row     <= 5'd0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 8'd0;
            tx_start    <= 1'b0;
            tx_data     <= 8'd0;
            busy        <= 1'b1;
        end else begin
            state       <= stateNext;
            clearAddr   <= clearAddrNext;
            echoPending <= echoPendingNext;
            cur_col     <= colNext;
            cur_row     <= rowNext;
            wr_en       <= wrEnNext;
            wr_addr     <= wrAddrNext;
            wr_data     <= wrDataNext;
            tx_start    <= txStartNext;
            tx_data     <= txDataNext;
            busy        <= (stateNext == CLEAR);
        end
    end
endmodule

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
Sequences all writes into the character RAM that the VGA text renderer scans. Takes received UART bytes, queues them in a small FIFO and interprets them as printable characters or control codes. Keeps the cursor, clears the screen, and echoes accepted bytes back to the UART transmitter. Sits between uart_rx/uart_tx and the write port of the dual-port character RAM; the VGA side reads that RAM independently.

Parameters:
COLS, 80, characters per row
ROWS, 30, rows per screen
ADDR_W, 12, character RAM address width; COLS*ROWS <= 2**ADDR_W
FIFO_DEPTH, 4, RX byte queue depth (power of two)
ECHO_EN, 1, 1 = echo accepted bytes to TX

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_busy  in  1  transmitter busy
tx_start  out  1  one-cycle strobe to start TX
tx_data  out  8  byte to transmit, stable while tx_start=1
wr_en  out  1  character RAM write enable, one cycle per write
wr_addr  out  ADDR_W  write address = row*COLS+col
wr_data  out  8  ASCII code to write
cur_col  out  7  cursor column, 0..COLS-1
cur_row  out  5  cursor row, 0..ROWS-1
busy  out  1  high while in CLEAR
overflow  out  1  sticky, RX byte dropped

Behaviour:
- Reset (async, rst_n=0): state=CLEAR, clear_addr=0, FIFO empty, cursor (0,0). All outputs are 0, except busy=1.
- All outputs are registered.
- FIFO push on rx_valid:
  - Accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow is set to 1. Only reset clears overflow.
- CLEAR:
  - Each cycle: wr_en=1, wr_addr=clear_addr, wr_data=0x20, then clear_addr++.
  - After the write to address COLS*ROWS-1: clear_addr=0, busy=0, state goes to IDLE.
  - A full clear is exactly COLS*ROWS consecutive write cycles.
  - FIFO keeps accepting pushes during CLEAR.
  - Reset mid-clear restarts the sweep at 0.
- IDLE: if FIFO not empty, pop the byte into cur_byte and go to PROC. Otherwise stay.
- PROC is one cycle and acts on cur_byte:
  - 0x20..0x7E: write cur_byte at the cursor, then advance col.
    - If col=COLS-1: col=0, row++.
    - If row=ROWS-1 also: row=0 (wrap to top, no scroll).
  - 0x0D: col=0, no write.
  - 0x0A: row++ with wrap to 0, no write.
  - 0x08: if col>0, col-- and write 0x20 at the new position. If col=0, no change and no write.
  - 0x0C: cursor to (0,0), state goes to CLEAR (busy=1 from the next cycle).
  - Any other byte: ignored, no echo, back to IDLE.
  - Byte accepted and ECHO_EN=1: go to ECHO (after CLEAR completes, when the byte was 0x0C). Otherwise go to IDLE.
- ECHO:
  - Wait while tx_busy=1.
  - Then tx_start=1 for exactly one cycle with tx_data=cur_byte, and go to IDLE.
  - While in ECHO, tx_start is never asserted with tx_busy=1.
- Latency: rx_valid sampled at edge E0 with state IDLE and FIFO empty. E1: pop. E2: wr_en/wr_addr/wr_data registered, high for one cycle. The echo tx_start follows no earlier than E3.
- Throughput: at most one byte per 3 cycles (IDLE, PROC, ECHO) when TX is free.
- wr_en is never high outside CLEAR or PROC.
- cur_col and cur_row never leave range.

Test Plan:
- Release rst_n -> exactly 2400 wr_en cycles, wr_addr 0..2399 ascending, wr_data=0x20. busy falls the cycle after addr 2399. cur_col=0, cur_row=0.
- After clear, rx 0x41 -> wr_en at E2 with wr_addr=0, wr_data=0x41. cur_col=1. tx_start one cycle with tx_data=0x41.
- Cursor at (79,29), rx 0x5A -> write addr 2399 data 0x5A, cursor (0,0). Then 0x0A at row 29 -> row 0. Then 0x0D at col 79 -> col 0.
- At col 0, rx 0x08 -> no wr_en, cursor unchanged. At col 5 row 2, rx 0x08 -> write 0x20 at addr 164, col 4.
- During reset clear, send 6 bytes 0x61..0x66 back-to-back -> 0x61..0x64 written at addr 0..3 after clear, overflow=1, 0x65/0x66 never written.
- tx_busy held high 100 cycles during echo of 0x42 -> no tx_start until tx_busy falls, then exactly one pulse with tx_data=0x42. Next FIFO byte is not popped before that pulse.
